// File: rtl/debug_scan_pkg.sv
// Shared definitions for the debug scan master.
// Holds the default scan/IR widths and the FSM state encoding used by
// debug_scan_master.
package debug_scan_pkg;

    localparam int unsigned DefaultSrWidth = 38;
    localparam int unsigned DefaultIrWidth = 2;

    // Scan sequencer states, kept as plain constants for legacy tooling.
    typedef logic [2:0] scan_state_t;

    localparam scan_state_t StIdle = 3'd0;
    localparam scan_state_t StUir  = 3'd1;
    localparam scan_state_t StCdr  = 3'd2;
    localparam scan_state_t StSdr  = 3'd3;
    localparam scan_state_t StUdr  = 3'd4;
    localparam scan_state_t StRti  = 3'd5;
    localparam scan_state_t StDone = 3'd6;

endpackage

// File: rtl/debug_scan_tck_gen.sv
// Scan clock generator.
// While run is high, tck toggles every TCK_DIV clk cycles starting low.
// While run is low, tck is held low and the phase counter is cleared.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   run            enable toggling
//   tck            generated scan clock
//   tck_rise       one-cycle enable: tck goes high at the coming clk edge
//   tck_fall       one-cycle enable: tck goes low at the coming clk edge
module debug_scan_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int unsigned PhaseW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(TCK_DIV - 1);

    logic [PhaseW-1:0] phase_q, phase_d;
    logic              tck_q, tck_d;
    logic              toggle;

    assign toggle   = run && (phase_q == PhaseLast);
    assign tck_rise = toggle && !tck_q;
    assign tck_fall = toggle && tck_q;
    assign tck      = tck_q;

    always_comb begin
        phase_d = phase_q;
        tck_d   = tck_q;
        if (!run) begin
            phase_d = '0;
            tck_d   = 1'b0;
        end else if (toggle) begin
            phase_d = '0;
            tck_d   = ~tck_q;
        end else begin
            phase_d = phase_q + PhaseW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            tck_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            tck_q   <= tck_d;
        end
    end

endmodule

// File: rtl/debug_scan_master.sv
// Virtual JTAG scan master.
// Accepts a command (IR value + data word), walks the virtual JTAG sequence
// UIR -> CDR -> SDR (SR_WIDTH bits, LSB first) -> UDR -> RTI, then presents
// the captured data and IR status on a response handshake.
// Ports:
//   clk, reset_n                       clock and asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_data   command handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_ir_out  response handshake
//   tck/tdi/tdo                        serial scan link
//   ir_in/ir_out                       virtual IR value driven / status returned
//   vs_uir/vs_cdr/vs_sdr/vs_udr/jtag_state_rti  state strobes
//   busy                               high whenever not idle
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int unsigned SR_WIDTH = DefaultSrWidth,
    parameter int unsigned IR_WIDTH = DefaultIrWidth,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti,
    output logic                busy
);

    localparam int unsigned BitCntW = $clog2(SR_WIDTH + 1);
    localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(SR_WIDTH - 1);

    scan_state_t         state_q, state_d;
    logic [SR_WIDTH-1:0] sr_q, sr_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
    logic [SR_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
    logic                tdi_q, tdi_d;
    // Keeps cmd_ready low until the first edge after reset release.
    logic                ready_en_q;

    logic run, tck_rise, tck_fall;

    assign run = (state_q != StIdle) && (state_q != StDone);

    debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .tck      (tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    assign cmd_ready      = ready_en_q && (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign rsp_valid      = (state_q == StDone);
    assign vs_uir         = (state_q == StUir);
    assign vs_cdr         = (state_q == StCdr);
    assign vs_sdr         = (state_q == StSdr);
    assign vs_udr         = (state_q == StUdr);
    assign jtag_state_rti = (state_q == StRti);
    assign tdi            = tdi_q;
    assign ir_in          = ir_in_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_ir_out     = rsp_ir_q;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        ir_in_d    = ir_in_q;
        rsp_data_d = rsp_data_q;
        rsp_ir_d   = rsp_ir_q;
        tdi_d      = tdi_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    state_d   = StUir;
                    ir_in_d   = cmd_ir;
                    sr_d      = cmd_data;
                    bit_cnt_d = '0;
                    tdi_d     = 1'b0;
                end
            end
            StUir: begin
                if (tck_rise) begin
                    rsp_ir_d = ir_out;
                end
                if (tck_fall) begin
                    state_d = StCdr;
                end
            end
            StCdr: begin
                if (tck_fall) begin
                    state_d = StSdr;
                    tdi_d   = sr_q[0];
                end
            end
            StSdr: begin
                if (tck_rise) begin
                    sr_d = {tdo, sr_q[SR_WIDTH-1:1]};
                end
                if (tck_fall) begin
                    if (bit_cnt_q == BitCntLast) begin
                        state_d   = StUdr;
                        bit_cnt_d = '0;
                        tdi_d     = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                        // sr_q already holds the shifted word from the preceding rise.
                        tdi_d     = sr_q[0];
                    end
                end
            end
            StUdr: begin
                if (tck_fall) begin
                    state_d = StRti;
                end
            end
            StRti: begin
                if (tck_fall) begin
                    state_d    = StDone;
                    rsp_data_d = sr_q;
                end
            end
            StDone: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tdi_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            ir_in_q    <= '0;
            rsp_data_q <= '0;
            rsp_ir_q   <= '0;
            tdi_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            ir_in_q    <= ir_in_d;
            rsp_data_q <= rsp_data_d;
            rsp_ir_q   <= rsp_ir_d;
            tdi_q      <= tdi_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_scan_master.sv
module tb_debug_scan_master;

    localparam int SW   = 38;
    localparam int IW   = 2;
    localparam int DIV  = 2;
    localparam int LAT  = (SW + 4) * 2 * DIV;
    localparam int LAT1 = (SW + 4) * 2;
    localparam int RW   = 10 + 2 * IW + SW;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // Main instance (TCK_DIV = 2)
    logic          cmd_valid = 1'b0, cmd_ready;
    logic [IW-1:0] cmd_ir = '0;
    logic [SW-1:0] cmd_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [SW-1:0] rsp_data;
    logic [IW-1:0] rsp_ir_out, ir_in;
    logic [IW-1:0] ir_out = '0;
    logic          tck, tdi, tdo;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy;

    // Second instance (TCK_DIV = 1) for back-to-back traffic, tdo looped back
    logic          cmd_valid1 = 1'b0, cmd_ready1;
    logic [IW-1:0] cmd_ir1 = '0;
    logic [SW-1:0] cmd_data1 = '0;
    logic          rsp_valid1, rsp_ready1 = 1'b1;
    logic [SW-1:0] rsp_data1;
    logic [IW-1:0] rsp_ir_out1, ir_in1;
    logic [IW-1:0] ir_out1 = '0;
    logic          tck1, tdi1;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1, busy1;

    // 0: loopback, 1: tied high, 2: random bit changed on every tck fall
    int   tdo_mode = 0;
    logic tdo_rand = 1'b0;
    assign tdo = (tdo_mode == 0) ? tdi : ((tdo_mode == 1) ? 1'b1 : tdo_rand);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observations of the serial link, gathered per command
    logic          tdi_seen[$];
    logic          tdo_seen[$];
    int            c_uir, c_cdr, c_sdr, c_udr, c_rti;
    logic [IW-1:0] exp_ir_in = '0;
    logic          tck_prev = 1'b0;

    debug_scan_master #(
        .SR_WIDTH (SW),
        .IR_WIDTH (IW),
        .TCK_DIV  (DIV)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_ir_out     (rsp_ir_out),
        .tck            (tck),
        .tdi            (tdi),
        .tdo            (tdo),
        .ir_in          (ir_in),
        .ir_out         (ir_out),
        .vs_uir         (vs_uir),
        .vs_cdr         (vs_cdr),
        .vs_sdr         (vs_sdr),
        .vs_udr         (vs_udr),
        .jtag_state_rti (jtag_state_rti),
        .busy           (busy)
    );

    debug_scan_master #(
        .SR_WIDTH (SW),
        .IR_WIDTH (IW),
        .TCK_DIV  (1)
    ) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid1),
        .cmd_ready      (cmd_ready1),
        .cmd_ir         (cmd_ir1),
        .cmd_data       (cmd_data1),
        .rsp_valid      (rsp_valid1),
        .rsp_ready      (rsp_ready1),
        .rsp_data       (rsp_data1),
        .rsp_ir_out     (rsp_ir_out1),
        .tck            (tck1),
        .tdi            (tdi1),
        .tdo            (tdi1),
        .ir_in          (ir_in1),
        .ir_out         (ir_out1),
        .vs_uir         (vs_uir1),
        .vs_cdr         (vs_cdr1),
        .vs_sdr         (vs_sdr1),
        .vs_udr         (vs_udr1),
        .jtag_state_rti (rti1),
        .busy           (busy1)
    );

    always @(posedge clk) cyc++;

    // Link monitor: strobe exclusivity, ir_in stability, idle tck, bit capture.
    always @(posedge clk) begin
        logic [4:0] strobes;
        #1;
        if (reset_n) begin
            strobes = {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti};
            n_checks++;
            if ($countones(strobes) > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot: got %b, want at most one bit set", strobes);
            end
            if (busy) begin
                n_checks++;
                if (ir_in !== exp_ir_in) begin
                    n_fail++;
                    $display("FAIL ir_in_stable: got %b, want %b", ir_in, exp_ir_in);
                end
            end
            if (!busy || rsp_valid) begin
                n_checks++;
                if (tck !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tck_idle_low: got %b, want 0", tck);
                end
            end
            if (vs_uir) c_uir++;
            if (vs_cdr) c_cdr++;
            if (vs_sdr) c_sdr++;
            if (vs_udr) c_udr++;
            if (jtag_state_rti) c_rti++;
            if (tck && !tck_prev && vs_sdr) begin
                tdi_seen.push_back(tdi);
                tdo_seen.push_back(tdo);
            end
            if (!tck && tck_prev) tdo_rand = 1'($urandom_range(0, 1));
        end
        tck_prev = tck;
    end

    function automatic logic [SW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[SW-1:0];
    endfunction

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid got %b, want 1 within 2000 cycles", rsp_valid);
        end
    endtask

    // Issues one command; with hold set, cmd_valid stays high afterwards
    // carrying the inverted IR and data.
    task automatic do_cmd(input logic [IW-1:0] ir, input logic [SW-1:0] data, input bit hold,
                          output int lat);
        int guard = 0;
        @(negedge clk);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready got %b, want 1", cmd_ready);
            cmd_valid = 1'b0;
            lat = -1;
            return;
        end
        exp_ir_in = ir;
        tdi_seen.delete();
        tdo_seen.delete();
        c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0;
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_ir   = ~ir;
            cmd_data = ~data;
        end else begin
            cmd_valid = 1'b0;
        end
        wait_rsp(lat);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    function automatic logic [SW-1:0] q2v(input logic q[$]);
        logic [SW-1:0] v = '0;
        for (int i = 0; i < q.size() && i < SW; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic test_reset();
        logic [RW-1:0] v;
        #2 reset_n = 1'b0;
        #1;
        v = {tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy, cmd_ready,
             rsp_valid, rsp_ir_out, ir_in, rsp_data};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", v);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, want 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b, want 1", cmd_ready);
        end
    endtask

    task automatic test_loopback();
        int lat;
        logic [SW-1:0] d = 38'h2A_AAAA_AAAA;
        tdo_mode = 0;
        ir_out   = 2'b11;
        do_cmd(2'b01, d, 1'b0, lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL loop_latency: got %0d, want %0d", lat, LAT);
        end
        n_checks++;
        if (rsp_data !== d) begin
            n_fail++;
            $display("FAIL loop_data: got %h, want %h", rsp_data, d);
        end
        n_checks++;
        if (q2v(tdi_seen) !== d || tdi_seen.size() != SW) begin
            n_fail++;
            $display("FAIL loop_tdi_seq: got %h (%0d bits), want %h (%0d bits)",
                     q2v(tdi_seen), tdi_seen.size(), d, SW);
        end
        n_checks++;
        if (rsp_ir_out !== 2'b11) begin
            n_fail++;
            $display("FAIL loop_ir_out: got %b, want 11", rsp_ir_out);
        end
        handshake();
    endtask

    task automatic test_strobes();
        int lat;
        tdo_mode = 1;
        ir_out   = 2'b10;
        do_cmd(2'b10, rand_word(), 1'b0, lat);
        n_checks++;
        if (rsp_data !== {SW{1'b1}}) begin
            n_fail++;
            $display("FAIL strobe_data: got %h, want all ones", rsp_data);
        end
        n_checks++;
        if (rsp_ir_out !== 2'b10) begin
            n_fail++;
            $display("FAIL strobe_ir_out: got %b, want 10", rsp_ir_out);
        end
        n_checks++;
        if (c_uir != 2 * DIV || c_cdr != 2 * DIV || c_udr != 2 * DIV || c_rti != 2 * DIV) begin
            n_fail++;
            $display("FAIL strobe_short_len: got uir=%0d cdr=%0d udr=%0d rti=%0d, want %0d each",
                     c_uir, c_cdr, c_udr, c_rti, 2 * DIV);
        end
        n_checks++;
        if (c_sdr != SW * 2 * DIV) begin
            n_fail++;
            $display("FAIL strobe_sdr_len: got %0d cycles, want %0d", c_sdr, SW * 2 * DIV);
        end
        handshake();
    endtask

    task automatic test_random();
        int lat;
        logic [SW-1:0] d;
        logic [IW-1:0] ir, iro;
        tdo_mode = 2;
        for (int k = 0; k < 3; k++) begin
            d   = rand_word();
            ir  = IW'($urandom);
            iro = IW'($urandom);
            ir_out = iro;
            do_cmd(ir, d, 1'b0, lat);
            n_checks++;
            if (lat !== LAT) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d, want %0d", k, lat, LAT);
            end
            n_checks++;
            if (q2v(tdi_seen) !== d || tdi_seen.size() != SW) begin
                n_fail++;
                $display("FAIL rand_tdi_seq[%0d]: got %h (%0d bits), want %h", k,
                         q2v(tdi_seen), tdi_seen.size(), d);
            end
            n_checks++;
            if (rsp_data !== q2v(tdo_seen) || tdo_seen.size() != SW) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h, want %h", k, rsp_data, q2v(tdo_seen));
            end
            n_checks++;
            if (rsp_ir_out !== iro) begin
                n_fail++;
                $display("FAIL rand_ir_out[%0d]: got %b, want %b", k, rsp_ir_out, iro);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [SW-1:0] d = rand_word();
        logic [IW-1:0] ir = IW'($urandom);
        logic [IW-1:0] iro = IW'($urandom);
        logic [SW+IW+2:0] got, want;
        tdo_mode = 0;
        ir_out   = iro;
        do_cmd(ir, d, 1'b1, lat);
        n_checks++;
        if (lat !== LAT || rsp_data !== d) begin
            n_fail++;
            $display("FAIL bp_first: got lat=%0d data=%h, want lat=%0d data=%h", lat, rsp_data,
                     LAT, d);
        end
        want = {1'b1, d, iro, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            got = {rsp_valid, rsp_data, rsp_ir_out, tck, cmd_ready};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h, want %h", i, got, want);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_ir_in = ~ir;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got ready=%b busy=%b valid=%b, want 1 0 0", cmd_ready,
                     busy, rsp_valid);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || ir_in !== ~ir) begin
            n_fail++;
            $display("FAIL bp_reaccept: got busy=%b ready=%b ir_in=%b, want 1 0 %b", busy,
                     cmd_ready, ir_in, ~ir);
        end
        wait_rsp(lat);
        n_checks++;
        if (lat !== LAT || rsp_data !== ~d) begin
            n_fail++;
            $display("FAIL bp_second: got lat=%0d data=%h, want lat=%0d data=%h", lat, rsp_data,
                     LAT, ~d);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        int lat;
        int guard = 0;
        logic [RW-1:0] v;
        logic [SW-1:0] d = rand_word();
        tdo_mode = 0;
        @(negedge clk);
        cmd_ir    = 2'b11;
        cmd_data  = d;
        cmd_valid = 1'b1;
        exp_ir_in = 2'b11;
        tdi_seen.delete();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        while (tdi_seen.size() < 17 && guard < 1000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        n_checks++;
        if (tdi_seen.size() != 17 || vs_sdr !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reach: got %0d bits sdr=%b, want 17 bits sdr=1",
                     tdi_seen.size(), vs_sdr);
        end
        #1 reset_n = 1'b0;
        #1;
        v = {tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti, busy, cmd_ready,
             rsp_valid, rsp_ir_out, ir_in, rsp_data};
        n_checks++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h, want 0", v);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        d = rand_word();
        do_cmd(2'b01, d, 1'b0, lat);
        n_checks++;
        if (lat !== LAT || rsp_data !== d) begin
            n_fail++;
            $display("FAIL midrst_after: got lat=%0d data=%h, want lat=%0d data=%h", lat,
                     rsp_data, LAT, d);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] d[3];
        int t_acc, t_prev, lat, guard;
        for (int k = 0; k < 3; k++) d[k] = rand_word();
        rsp_ready1 = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cmd_data1  = d[k];
            cmd_ir1    = IW'(k);
            cmd_valid1 = 1'b1;
            guard = 0;
            while (!cmd_ready1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            @(posedge clk);
            #1;
            t_acc = cyc;
            if (k < 2) cmd_data1 = d[k+1];
            else cmd_valid1 = 1'b0;
            if (k > 0) begin
                n_checks++;
                if (t_acc - t_prev != LAT1 + 2) begin
                    n_fail++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles, want %0d", k, t_acc - t_prev,
                             LAT1 + 2);
                end
            end
            t_prev = t_acc;
            guard = 0;
            while (!rsp_valid1 && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
            lat = cyc - t_acc;
            n_checks++;
            if (lat != LAT1 || rsp_data1 !== d[k]) begin
                n_fail++;
                $display("FAIL b2b_cmd[%0d]: got lat=%0d data=%h, want lat=%0d data=%h", k, lat,
                         rsp_data1, LAT1, d[k]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_strobes();
        test_random();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debug_scan_master.md
DEBUG_SCAN_MASTER -- requirements
Module: debug_scan_master

Interface
REQ-001 SHALL have parameter SR_WIDTH, default 38, scan data register length in bits.
REQ-002 SHALL have parameter IR_WIDTH, default 2, virtual instruction register width.
REQ-003 SHALL have parameter TCK_DIV, default 2, tck half-period in clk cycles; legal values are 1 or greater.
REQ-004 Ports: clk  in  1  sole clock, all logic on its rising edge.
REQ-005 Ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-006 Ports: cmd_valid  in  1 / cmd_ready  out  1 / cmd_ir  in  IR_WIDTH / cmd_data  in  SR_WIDTH  scan command handshake.
REQ-007 Ports: rsp_valid  out  1 / rsp_ready  in  1 / rsp_data  out  SR_WIDTH / rsp_ir_out  out  IR_WIDTH  scan result handshake.
REQ-008 Ports: tck  out  1 / tdi  out  1 / tdo  in  1  serial scan link to the debug slave.
REQ-009 Ports: ir_in  out  IR_WIDTH / ir_out  in  IR_WIDTH  virtual IR value driven and status returned.
REQ-010 Ports: vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti  out  1 each  virtual JTAG state strobes.
REQ-011 Ports: busy  out  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RTI, DONE.
REQ-013 cmd_ready SHALL be high only in IDLE; accept = cmd_valid and cmd_ready at a clk edge.
REQ-014 On accept: latch cmd_ir to ir_in, load cmd_data into the shift register, clear the phase counter, keep tck low, enter UIR.
REQ-015 Outside IDLE and DONE, tck SHALL toggle every TCK_DIV clk cycles, starting low, giving a period of 2*TCK_DIV clk cycles.
REQ-016 In IDLE and DONE, tck SHALL be held low.
REQ-017 State advance, strobe updates and tdi updates SHALL occur only on the clk cycle in which tck falls.
REQ-018 tdo and ir_out SHALL be sampled only on the clk cycle in which tck rises.
REQ-019 UIR, CDR, UDR and RTI SHALL each last exactly one tck period; SDR SHALL last exactly SR_WIDTH tck periods.
REQ-020 Strobes SHALL be one-hot with state: vs_uir in UIR, vs_cdr in CDR, vs_sdr in SDR, vs_udr in UDR, jtag_state_rti in RTI; all strobes SHALL be low otherwise.
REQ-021 In SDR, tdi SHALL equal shift register bit 0 (LSB first).
REQ-022 On each tck rise in SDR, the shift register SHALL load {tdo, sr[SR_WIDTH-1:1]}.
REQ-023 In all states other than SDR, tdi SHALL be 0.
REQ-024 On the tck rise in UIR, ir_out SHALL be latched into rsp_ir_out.
REQ-025 The SDR bit counter SHALL be ceil(log2(SR_WIDTH+1)) bits wide and SHALL exit SDR after the SR_WIDTH-th tck fall.
REQ-026 On entering DONE: rsp_valid goes high and rsp_data holds the shift register.
REQ-027 rsp_valid SHALL first be high exactly (SR_WIDTH+4)*2*TCK_DIV clk cycles after the accept edge.
REQ-028 rsp_data, rsp_ir_out and rsp_valid SHALL hold stable until rsp_valid and rsp_ready are both high.
REQ-029 On that response handshake the block SHALL return to IDLE; cmd_ready SHALL rise on the next cycle, so there is no same-cycle re-accept.
REQ-030 cmd_valid asserted while busy SHALL be ignored, with no effect on the shift register or state.
REQ-031 ir_in SHALL remain stable from accept until IDLE is re-entered.

Reset
REQ-032 Asserting reset_n low SHALL immediately, at any state including mid-SDR, force state to IDLE.
REQ-033 During reset, outputs SHALL be: tck=0, tdi=0, all strobes=0, busy=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_ir_out=0, ir_in=0.
REQ-034 The phase counter, bit counter and shift register SHALL be cleared during reset.
REQ-035 cmd_ready SHALL first go high on the first clk edge after reset_n deasserts.

Structure
REQ-036 A shared package debug_scan_pkg SHALL hold the state enum and the default SR_WIDTH and IR_WIDTH constants.
REQ-037 A single sub-module debug_scan_tck_gen SHALL produce tck plus one-cycle tck_rise and tck_fall enables from TCK_DIV and a run input.
REQ-038 The top level SHALL hold the FSM, counters and shift register.

Verification
REQ-039 Loopback: SR_WIDTH=38, TCK_DIV=2, tdo looped to tdi, cmd_ir=2'b01, cmd_data=38'h2A_AAAA_AAAA -> rsp_data=38'h2A_AAAA_AAAA, rsp_valid high at cycle 168 after accept, ir_in=2'b01 throughout.
REQ-040 Strobe count: tdo tied 1, ir_out=2'b10 -> rsp_data all ones, rsp_ir_out=2'b10, exactly 1 tck period each of vs_uir/vs_cdr/vs_udr/jtag_state_rti, exactly 38 periods of vs_sdr, strobes never overlapping.
REQ-041 Backpressure: rsp_ready low for 10 cycles after rsp_valid, cmd_valid held high -> response held stable, tck low, cmd_ready low until 1 cycle after the handshake.
REQ-042 Mid-operation reset: reset_n pulsed low at SDR bit 17 -> all outputs immediately at reset values; next command after release completes normally with correct data.
REQ-043 Back-to-back: TCK_DIV=1, three consecutive commands with rsp_ready tied 1 -> each completes in 84 cycles, data correct, one IDLE cycle between commands.
